prbs_check: RTL and testbench
=============================

Name: prbs_check

Overview:
- Downstream checker for the x^29 + x^19 + 1 PRBS bit stream used in our link and loopback tests.
- Consumes one bit per valid cycle and self-synchronises to the sequence.
- Once locked, counts bit errors and checked bits for BER measurement.
- Declares loss of lock when the error density gets too high.

Parameters:
- LOCK_COUNT, 64: consecutive matching bits required in SEARCH to declare lock (range 1..65535).
- WINDOW, 256: LOCKED-state observation window length in valid bits (range 2..65536).
- UNLOCK_ERRORS, 8: errors within one window that force loss of lock (range 1..WINDOW).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_bit  in  1  received stream bit.
- in_valid  in  1  in_bit is sampled on this edge; when 0, all state holds.
- clear_counts  in  1  synchronous clear of err_count and bit_count.
- locked  out  1  checker is synchronised.
- err_pulse  out  1  one-cycle pulse: the last sampled bit mismatched while LOCKED.
- err_count  out  32  errors detected while LOCKED; saturates at 32'hFFFFFFFF.
- bit_count  out  32  bits checked while LOCKED; saturates at 32'hFFFFFFFF.

Behaviour:
- Reset (async, reset_n=0) clears all state:
  - state=SEARCH; history, fill, match, window and error counters = 0.
  - All outputs = 0.
- Sequence model:
  - hist[28:0] holds past bits; hist[0] is the newest.
  - pred = hist[18] ^ hist[28], i.e. s(n) = s(n-19) ^ s(n-29).
  - mism = in_bit ^ pred.
  - Every valid cycle: hist <= {hist[27:0], b}. In SEARCH, b = in_bit. In LOCKED, b = pred (free-running), so one flipped line bit gives exactly one error.
- SEARCH state:
  - fill counts valid bits and saturates at 29. No comparison is made while fill<29.
  - Once fill==29, for each valid bit:
    - mism=1 or hist==0: match <= 0. All-zero history never counts, so a constant-0 stream never locks.
    - otherwise: match <= match+1.
  - When the incremented match equals LOCK_COUNT: go to LOCKED on that edge; locked=1 from that edge. The lock-completing bit is not counted in bit_count.
  - err_pulse=0; no counters change in SEARCH.
- LOCKED state, per valid bit:
  - bit_count += 1 (saturating).
  - On mism: err_count += 1 (saturating), err_pulse=1 for exactly the following cycle, win_err += 1.
  - win_pos counts 0..WINDOW-1. On the bit where win_pos==WINDOW-1, win_pos and win_err reset to 0 after that bit's error has been evaluated.
  - If the incremented win_err reaches UNLOCK_ERRORS: go to SEARCH on that edge.
    - locked=0; fill, match, win_pos and win_err cleared.
    - The current bit is still counted in both counters.
  - Unlock takes priority over the window wrap on the same bit.
- err_pulse is 0 on any cycle with in_valid=0 on the previous edge.
- clear_counts=1 zeroes err_count and bit_count on that edge, with priority over a simultaneous increment. It does not affect locked, window state or err_pulse.
- Latency: one edge from in_bit sample to err_pulse, counters and locked.
- Reset asserted mid-operation returns immediately to the reset state; no partial counts are preserved.

Test Plan:
- Lock: drive in_bit from the LFSR generator with seed=32'hDEADBEEF and in_valid=1 -> locked=1 no later than the edge sampling bit index 95 (LOCK_COUNT=64); err_count=0 and err_pulse never high over 10000 further bits; bit_count equals the number of bits sampled after lock.
- Single error: after lock, invert one bit -> err_pulse high for exactly one cycle, one edge later; err_count=1; no further errors (no 19/29-bit echoes); locked stays 1.
- Loss of lock: after lock, invert 8 bits within 100 consecutive bits -> locked=0 on the edge sampling the 8th error; err_count=8; relock within 29+64 valid bits of clean stream.
- Window boundary: 7 errors in one window, then 7 in the next -> locked stays 1; err_count=14.
- Stalls and zero stream: same as the lock test but with in_valid toggling pseudo-randomly (~50%) -> identical lock point measured in valid bits and identical counts; an all-zero stream for 1000 bits -> locked never asserts.
- Clear and reset: clear_counts on the same cycle as an error -> err_count=0; reset_n pulsed low while locked -> all outputs 0 immediately, then normal relock.

Source files
------------

// File: rtl/prbs_check.sv
// rtl/prbs_check.sv - x^29 + x^19 + 1 PRBS checker with self-sync, BER counters and loss-of-lock detection
module prbs_check #(
    parameter int LOCK_COUNT    = 64,
    parameter int WINDOW        = 256,
    parameter int UNLOCK_ERRORS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_bit,
    input  logic        in_valid,
    input  logic        clear_counts,
    output logic        locked,
    output logic        err_pulse,
    output logic [31:0] err_count,
    output logic [31:0] bit_count
);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t      state;
    logic [28:0] hist;
    logic [4:0]  fill;
    logic [15:0] match;
    logic [16:0] win_pos;
    logic [16:0] win_err;

    logic        pred;
    logic        mism;
    logic [15:0] match_inc;
    logic [16:0] win_err_inc;

    assign pred        = hist[18] ^ hist[28];
    assign mism        = in_bit ^ pred;
    assign match_inc   = match + 16'd1;
    assign win_err_inc = win_err + 17'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SEARCH;
            hist      <= '0;
            fill      <= '0;
            match     <= '0;
            win_pos   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                if (state == SEARCH) begin
                    hist <= {hist[27:0], in_bit};
                    if (fill != 5'd29) begin
                        fill <= fill + 5'd1;
                    end else if (mism || hist == '0) begin
                        // An all-zero history is a degenerate fixed point, never trust it
                        match <= '0;
                    end else if (match_inc == 16'(LOCK_COUNT)) begin
                        match   <= '0;
                        state   <= LOCKED;
                        locked  <= 1'b1;
                        win_pos <= '0;
                        win_err <= '0;
                    end else begin
                        match <= match_inc;
                    end
                end else begin
                    // Free-run on our own prediction so a line error cannot echo at taps 19/29
                    hist <= {hist[27:0], pred};
                    if (bit_count != 32'hFFFF_FFFF)
                        bit_count <= bit_count + 32'd1;
                    if (mism) begin
                        err_pulse <= 1'b1;
                        if (err_count != 32'hFFFF_FFFF)
                            err_count <= err_count + 32'd1;
                    end
                    if (mism && win_err_inc == 17'(UNLOCK_ERRORS)) begin
                        state   <= SEARCH;
                        locked  <= 1'b0;
                        fill    <= '0;
                        match   <= '0;
                        win_pos <= '0;
                        win_err <= '0;
                    end else if (win_pos == 17'(WINDOW - 1)) begin
                        win_pos <= '0;
                        win_err <= '0;
                    end else begin
                        win_pos <= win_pos + 17'd1;
                        if (mism)
                            win_err <= win_err_inc;
                    end
                end
            end
            if (clear_counts) begin
                err_count <= '0;
                bit_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs_check.sv
// tb/tb_prbs_check.sv - directed self-checking bench for prbs_check
module tb_prbs_check;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_bit = 1'b0;
    logic        in_valid = 1'b0;
    logic        clear_counts = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_count;
    logic [31:0] bit_count;

    prbs_check dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_bit       (in_bit),
        .in_valid     (in_valid),
        .clear_counts (clear_counts),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] seed = 32'hDEADBEEF;
    logic [28:0] g;
    int          since_lock = 0;
    int          pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic gen_next();
        logic b;
        b = g[18] ^ g[28];
        g = {g[27:0], b};
        return b;
    endfunction

    task automatic step(input logic b, input logic v, input logic clr);
        in_bit = b;
        in_valid = v;
        clear_counts = clr;
        @(posedge clk);
        #1;
        clear_counts = 1'b0;
        in_valid = 1'b0;
        if (err_pulse) pulses++;
    endtask

    task automatic send(input logic flip, input logic clr);
        logic was;
        logic b;
        was = locked;
        b = gen_next();
        step(b ^ flip, 1'b1, clr);
        if (was) since_lock++;
        else if (locked) since_lock = 0;
    endtask

    task automatic stall();
        step(1'($urandom_range(1)), 1'b0, 1'b0);
    endtask

    task automatic lock_up(output int n);
        n = 0;
        while (!locked && n < 200) begin
            send(1'b0, 1'b0);
            n++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        g = seed[28:0];
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        since_lock = 0;
    endtask

    task automatic align_window();
        while (since_lock % 256 != 0) send(1'b0, 1'b0);
    endtask

    initial begin
        int n;
        int guard;
        logic saw_lock;

        g = seed[28:0];
        @(posedge clk);
        #1;
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_pulse", {31'd0, err_pulse}, 32'd0);
        check("rst_err_count", err_count, 32'd0);
        check("rst_bit_count", bit_count, 32'd0);
        do_reset();

        // 29 fill bits + 64 matches: lock on the 93rd bit (index 92)
        lock_up(n);
        check("lock_bits", n, 32'd93);
        check("lock_bitcnt0", bit_count, 32'd0);
        pulses = 0;
        for (int i = 0; i < 10000; i++) send(1'b0, 1'b0);
        check("clean_pulses", pulses, 32'd0);
        check("clean_err_count", err_count, 32'd0);
        check("clean_bit_count", bit_count, 32'd10000);

        pulses = 0;
        send(1'b1, 1'b0);
        check("single_pulse", {31'd0, err_pulse}, 32'd1);
        check("single_err_count", err_count, 32'd1);
        send(1'b0, 1'b0);
        check("single_pulse_end", {31'd0, err_pulse}, 32'd0);
        for (int i = 0; i < 100; i++) send(1'b0, 1'b0);
        check("single_no_echo", pulses, 32'd1);
        check("single_err_count2", err_count, 32'd1);
        check("single_locked", {31'd0, locked}, 32'd1);

        send(1'b0, 1'b1);
        check("clear_err", err_count, 32'd0);
        check("clear_bits", bit_count, 32'd0);
        align_window();
        for (int i = 0; i <= 84; i++) begin
            send(i % 12 == 0, 1'b0);
            if (i == 72) check("unlock_hold7", {31'd0, locked}, 32'd1);
        end
        check("unlock_locked", {31'd0, locked}, 32'd0);
        check("unlock_err_count", err_count, 32'd8);
        lock_up(n);
        check("relock_bits", n, 32'd93);

        send(1'b0, 1'b1);
        align_window();
        pulses = 0;
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 256; i++) send(i % 30 == 0 && i <= 180, 1'b0);
        check("window_locked", {31'd0, locked}, 32'd1);
        check("window_err_count", err_count, 32'd14);
        check("window_pulses", pulses, 32'd14);

        do_reset();
        n = 0;
        guard = 0;
        while (!locked && n < 200 && guard < 1000) begin
            if ($urandom_range(1) == 1) begin
                send(1'b0, 1'b0);
                n++;
            end else begin
                stall();
            end
            guard++;
        end
        check("stall_lock_bits", n, 32'd93);
        pulses = 0;
        n = 0;
        while (n < 2000) begin
            if ($urandom_range(1) == 1) begin
                send(1'b0, 1'b0);
                n++;
            end else begin
                stall();
            end
        end
        check("stall_pulses", pulses, 32'd0);
        check("stall_err_count", err_count, 32'd0);
        check("stall_bit_count", bit_count, 32'd2000);
        send(1'b1, 1'b0);
        check("stall_err_pulse", {31'd0, err_pulse}, 32'd1);
        stall();
        check("stall_pulse_low", {31'd0, err_pulse}, 32'd0);
        check("stall_err_count1", err_count, 32'd1);

        send(1'b1, 1'b1);
        check("clr_err_same", err_count, 32'd0);
        check("clr_bits_same", bit_count, 32'd0);
        check("clr_pulse_kept", {31'd0, err_pulse}, 32'd1);
        check("clr_locked_kept", {31'd0, locked}, 32'd1);

        do_reset();
        saw_lock = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (locked) saw_lock = 1'b1;
        end
        check("zero_no_lock", {31'd0, saw_lock}, 32'd0);

        do_reset();
        lock_up(n);
        check("pre_areset_lock", n, 32'd93);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        check("areset_locked", {31'd0, locked}, 32'd0);
        check("areset_pulse", {31'd0, err_pulse}, 32'd0);
        check("areset_err", err_count, 32'd0);
        check("areset_bits", bit_count, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        g = seed[28:0];
        since_lock = 0;
        lock_up(n);
        check("post_areset_lock", n, 32'd93);
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
        check("post_areset_bits", bit_count, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
